quicksort_host: RTL
===================

// Module: quicksort_host
// PURPOSE
//  Initiator for the quicksort toggle-command interface (push/pop/clear/sort, rx_data/tx_data, full/empty/idle).
//  Takes one frame on a valid/ready input stream, clears the sorter, pushes the words, issues sort.
//  Then pops the sorted frame out on a valid/ready output stream. Sits between a stream source and a quicksort instance.
// PARAMETERS
//  A_D_MSB   7  data MSB; word width = A_D_MSB+1
//  A_P_MSB   3  sorter pointer MSB; frame counter width = A_P_MSB+2
//  CMD_GAP   4  cycles waited after each toggle before qs_idle is sampled (covers sorter sync latency), >=1
// PORTS
//  clk         in   1          clock
//  rstn        in   1          async reset, active low; same net as the sorter's rstn
//  enable      in   1          0: FSM frozen, s_ready=0, m_valid=0, no toggles issued
//  s_data      in   A_D_MSB+1  input word
//  s_valid     in   1          input word valid
//  s_last      in   1          last word of frame
//  s_ready     out  1          input accept
//  m_data      out  A_D_MSB+1  sorted output word
//  m_valid     out  1          output valid
//  m_last      out  1          last sorted word of frame
//  m_ready     in   1          output accept
//  qs_push     out  1          toggle: one edge = one push
//  qs_pop      out  1          toggle: one edge = one pop
//  qs_clear    out  1          toggle: one edge = clear
//  qs_sort     out  1          toggle: one edge = sort
//  qs_rx_data  out  A_D_MSB+1  word presented to sorter; stable from before push edge to end of gap
//  qs_tx_data  in   A_D_MSB+1  sorter head word
//  qs_full     in   1          sorter full
//  qs_empty    in   1          sorter empty
//  qs_idle     in   1          sorter ready for a command
//  ovf         out  1          sticky: frame exceeded sorter capacity; cleared by next CLEAR
//  cst, nst    out  3          current/next state, Gray-coded, for debug
// BEHAVIOUR
//  Reset: all outputs 0; cst=nst=ST_IDLE; word counter 0.
//  States (Gray(n)): IDLE=0 CLEAR=1 FILL=2 PUSH=3 SORT=4 DRAIN=5 POP=6.
//  Command issue: toggle level flips for exactly 1 cycle edge; then wait CMD_GAP cycles.
//   Then wait for qs_idle=1; command done. Never flip a toggle while a previous command is pending.
//  IDLE: s_valid&enable -> CLEAR. No word is consumed (s_ready=0).
//  CLEAR: issue clear; cnt<=0; ovf<=0; done -> FILL.
//  FILL: s_ready=1 for 1 cycle per word; on s_valid&s_ready:
//   qs_full=0 -> latch qs_rx_data, cnt++, -> PUSH.
//   qs_full=1 -> word dropped, ovf<=1, stay FILL.
//   Either case, s_last -> SORT after the push (if any) completes.
//  PUSH: issue push; done -> FILL, or SORT if the latched word was last.
//  SORT: issue sort; done -> DRAIN (cnt=0 frame impossible; frame always >=1 word).
//  DRAIN: m_valid=qs_idle&~qs_empty&(cnt!=0); m_data=qs_tx_data; m_last=(cnt==1).
//   On m_valid&m_ready: cnt--, -> POP. cnt==0 or qs_empty -> IDLE.
//  POP: issue pop; done -> DRAIN. m_valid=0 throughout POP.
//  s_ready=0 outside FILL: a new frame waits until drain finishes. m_data is held stable while m_valid=1.
//  enable drop mid-frame: freeze, including gap counter; a toggle already flipped stays flipped; resume on enable=1.
//  rstn mid-frame: toggles return to 0 together with the sorter's reset, so no spurious edge; partial frame lost.
//  Widths: cnt is A_P_MSB+2 bits, saturates at 2**(A_P_MSB+1); no wrap.
// STRUCTURE
//  quicksort_pkg: GRAY macro, host state localparams, command codes {CMD_CLEAR,CMD_PUSH,CMD_SORT,CMD_POP}.
//  Sub-module qs_cmd_toggler: cmd code + go in; four toggle regs, gap counter and idle wait inside; done pulse out.
//  Top holds FSM, counter, ovf and stream muxing.
// TESTING
//  Frame 5,3,9,1 (last on 1) -> 1 clear, 4 push, 1 sort edge; m_data 1,3,5,9; m_last only on 9.
//  Single-word frame 42 -> one push, sort issued, one output 42 with m_last=1, back to IDLE.
//  Frame of 20 words (capacity 16) -> 16 pushes; ovf=1; 16 sorted words out, last one flagged; ovf=0 after next CLEAR.
//  m_ready low 50 cycles during DRAIN -> m_valid and m_data held, no pop edge; resumes in order.
//  enable=0 for 30 cycles mid-FILL -> no toggles, s_ready=0; output is the correctly sorted frame.
//  rstn pulse mid-DRAIN -> all toggles and outputs 0, ST_IDLE; next frame sorts correctly.
//  Every test: checker asserts no toggle edge while qs_idle=0 after gap, and edges at least CMD_GAP apart.

Source files
------------

// File: rtl/quicksort_pkg.sv
// Shared encodings for the quicksort host: Gray-coded host states and sorter command codes.
// Pure declarations, no latency or backpressure of its own.
`ifndef GRAY
`define GRAY(n) ((n) ^ ((n) >> 1))
`endif

package quicksort_pkg;

  localparam logic [2:0] ST_IDLE_C  = `GRAY(3'd0);
  localparam logic [2:0] ST_CLEAR_C = `GRAY(3'd1);
  localparam logic [2:0] ST_FILL_C  = `GRAY(3'd2);
  localparam logic [2:0] ST_PUSH_C  = `GRAY(3'd3);
  localparam logic [2:0] ST_SORT_C  = `GRAY(3'd4);
  localparam logic [2:0] ST_DRAIN_C = `GRAY(3'd5);
  localparam logic [2:0] ST_POP_C   = `GRAY(3'd6);

  typedef enum logic [2:0] {
    ST_IDLE  = ST_IDLE_C,
    ST_CLEAR = ST_CLEAR_C,
    ST_FILL  = ST_FILL_C,
    ST_PUSH  = ST_PUSH_C,
    ST_SORT  = ST_SORT_C,
    ST_DRAIN = ST_DRAIN_C,
    ST_POP   = ST_POP_C
  } host_state_e;

  // Codes double as the bit index of each toggle inside the command toggler.
  typedef enum logic [1:0] {
    CMD_CLEAR = 2'd0,
    CMD_PUSH  = 2'd1,
    CMD_SORT  = 2'd2,
    CMD_POP   = 2'd3
  } qs_cmd_e;

endpackage

// File: rtl/qs_cmd_toggler.sv
// Issues one sorter command as a single toggle edge, waits CMD_GAP cycles, then waits for qs_idle.
// done pulses the cycle qs_idle is seen; go is ignored while busy; enable=0 freezes everything.
module qs_cmd_toggler
  import quicksort_pkg::*;
#(
  parameter int CMD_GAP = 4
) (
  input  logic    clk,
  input  logic    rstn,
  input  logic    enable,
  input  logic    go,
  input  qs_cmd_e cmd,
  input  logic    qs_idle,
  output logic    qs_clear,
  output logic    qs_push,
  output logic    qs_sort,
  output logic    qs_pop,
  output logic    busy,
  output logic    done
);

  localparam int GW = $clog2(CMD_GAP + 1);

  typedef enum logic [1:0] {T_IDLE, T_GAP, T_WAIT} tphase_e;

  tphase_e       phase_q, phase_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [3:0]    tog_q, tog_d;

  always_comb begin
    phase_d = phase_q;
    gap_d   = gap_q;
    tog_d   = tog_q;
    done    = 1'b0;
    if (enable) begin
      unique case (phase_q)
        T_IDLE: if (go) begin
          tog_d[cmd] = ~tog_q[cmd];
          gap_d      = GW'(CMD_GAP);
          phase_d    = T_GAP;
        end
        T_GAP: if (gap_q == GW'(1)) phase_d = T_WAIT;
               else gap_d = gap_q - GW'(1);
        T_WAIT: if (qs_idle) begin
          done    = 1'b1;
          phase_d = T_IDLE;
        end
        default: phase_d = T_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase_q <= T_IDLE;
      gap_q   <= '0;
      tog_q   <= '0;
    end else begin
      phase_q <= phase_d;
      gap_q   <= gap_d;
      tog_q   <= tog_d;
    end
  end

  assign busy     = (phase_q != T_IDLE);
  assign qs_clear = tog_q[CMD_CLEAR];
  assign qs_push  = tog_q[CMD_PUSH];
  assign qs_sort  = tog_q[CMD_SORT];
  assign qs_pop   = tog_q[CMD_POP];

endmodule

// File: rtl/quicksort_host.sv
// Loads one input frame into a toggle-command quicksort, sorts it and streams it back out in order.
// Latency is command-bound (gap + sorter busy per word); s_ready only in FILL, m_data held while m_valid.
module quicksort_host
  import quicksort_pkg::*;
#(
  parameter int A_D_MSB = 7,
  parameter int A_P_MSB = 3,
  parameter int CMD_GAP = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic [A_D_MSB:0] s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [A_D_MSB:0] m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready,
  output logic             qs_push,
  output logic             qs_pop,
  output logic             qs_clear,
  output logic             qs_sort,
  output logic [A_D_MSB:0] qs_rx_data,
  input  logic [A_D_MSB:0] qs_tx_data,
  input  logic             qs_full,
  input  logic             qs_empty,
  input  logic             qs_idle,
  output logic             ovf,
  output logic [2:0]       cst,
  output logic [2:0]       nst
);

  localparam int             CW      = A_P_MSB + 2;
  localparam logic [CW-1:0]  CNT_MAX = CW'(1) << (A_P_MSB + 1);

  host_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [A_D_MSB:0] rx_q, rx_d;
  logic             last_q, last_d;
  logic             go, busy, done;
  qs_cmd_e          cmd;

  qs_cmd_toggler #(.CMD_GAP(CMD_GAP)) u_toggler (
    .clk     (clk),
    .rstn    (rstn),
    .enable  (enable),
    .go      (go),
    .cmd     (cmd),
    .qs_idle (qs_idle),
    .qs_clear(qs_clear),
    .qs_push (qs_push),
    .qs_sort (qs_sort),
    .qs_pop  (qs_pop),
    .busy    (busy),
    .done    (done)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    rx_d    = rx_q;
    last_d  = last_q;
    go      = 1'b0;
    cmd     = CMD_CLEAR;
    s_ready = 1'b0;
    m_valid = 1'b0;
    if (enable) begin
      unique case (state_q)
        ST_IDLE: if (s_valid) state_d = ST_CLEAR;
        ST_CLEAR: begin
          go = ~busy;
          if (go) begin
            cnt_d = '0;
            ovf_d = 1'b0;
          end
          if (done) state_d = ST_FILL;
        end
        ST_FILL: begin
          s_ready = 1'b1;
          if (s_valid) begin
            if (!qs_full) begin
              rx_d    = s_data;
              last_d  = s_last;
              cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
              state_d = ST_PUSH;
            end else begin
              ovf_d = 1'b1;
              if (s_last) state_d = ST_SORT;
            end
          end
        end
        ST_PUSH: begin
          cmd = CMD_PUSH;
          go  = ~busy;
          if (done) state_d = last_q ? ST_SORT : ST_FILL;
        end
        ST_SORT: begin
          cmd = CMD_SORT;
          go  = ~busy;
          if (done) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          m_valid = qs_idle & ~qs_empty & (cnt_q != '0);
          if (m_valid && m_ready) begin
            cnt_d   = cnt_q - CW'(1);
            state_d = ST_POP;
          end else if (cnt_q == '0 || qs_empty) begin
            state_d = ST_IDLE;
          end
        end
        ST_POP: begin
          cmd = CMD_POP;
          go  = ~busy;
          if (done) state_d = ST_DRAIN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rx_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rx_q    <= rx_d;
      last_q  <= last_d;
    end
  end

  assign m_data     = m_valid ? qs_tx_data : '0;
  assign m_last     = m_valid & (cnt_q == CW'(1));
  assign qs_rx_data = rx_q;
  assign ovf        = ovf_q;
  assign cst        = state_q;
  assign nst        = state_d;

endmodule
